// File: rtl/genius_pkg.sv
// Shared definitions for the memory game: one-hot colour codes, sequencer
// state encoding and a one-hot check helper.
package genius_pkg;

   localparam logic [3:0] VERDE    = 4'b1000;
   localparam logic [3:0] AMARELO  = 4'b0100;
   localparam logic [3:0] AZUL     = 4'b0010;
   localparam logic [3:0] VERMELHO = 4'b0001;
   localparam logic [3:0] APAGADO  = 4'b0000;

   typedef enum logic [2:0] {
      OCIOSO,
      CARREGA,
      LE,
      ACENDE,
      APAGA,
      FIM
   } estado_t;

   function automatic logic eh_um_quente(input logic [3:0] codigo);
      return $countones(codigo) == 1;
   endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter: carrega has priority, then counts down and holds at zero.
// fim_tempo is high whenever the count is zero.
module contador_tempo #(
   parameter int W = 9
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic [W-1:0] valor,
   output logic         fim_tempo
);

   logic [W-1:0] contagem;

   always_ff @(posedge clock) begin
      if (reset) begin
         contagem <= '0;
      end else if (carrega) begin
         contagem <= valor;
      end else if (contagem != '0) begin
         contagem <= contagem - 1'b1;
      end
   end

   assign fim_tempo = (contagem == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays codes 0..ultimo from sequence memory on the LED: T_ON on, T_OFF off each;
// first code 2 cycles after iniciar. Optional VERIFICA_CODIGO_EN adds erro for non-one-hot codes.
module exibe_sequencia
   import genius_pkg::*;
#(
   parameter int T_ON   = 500,
   parameter int T_OFF  = 250,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [ADDR_W-1:0] ultimo,
   output logic [ADDR_W-1:0] endereco,
   input  logic [3:0]        dado_mem,
   output logic [3:0]        codigo_led,
   output logic              ocupado,
`ifdef VERIFICA_CODIGO_EN
   output logic              erro,
`endif
   output logic              pronto
);

   localparam int TW = $clog2(((T_ON > T_OFF) ? T_ON : T_OFF) + 1);
   // Reload with N-1 so the state lasts N cycles including the load cycle.
   localparam logic [TW-1:0] RECARGA_ON  = TW'(T_ON - 1);
   localparam logic [TW-1:0] RECARGA_OFF = TW'(T_OFF - 1);

   estado_t           estado, prox;
   logic [ADDR_W-1:0] ult_r;
   logic [3:0]        codigo_r;
   logic              carrega;
   logic [TW-1:0]     valor;
   logic              fim_tempo;

   contador_tempo #(.W(TW)) u_contador (
      .clock     (clock),
      .reset     (reset),
      .carrega   (carrega),
      .valor     (valor),
      .fim_tempo (fim_tempo)
   );

   always_comb begin
      prox    = estado;
      carrega = 1'b0;
      valor   = '0;
      case (estado)
         OCIOSO:  if (iniciar) prox = CARREGA;
         CARREGA: prox = LE;
         LE: begin
`ifdef VERIFICA_CODIGO_EN
            if (!eh_um_quente(dado_mem)) prox = OCIOSO;
            else
`endif
            begin
               prox    = ACENDE;
               carrega = 1'b1;
               valor   = RECARGA_ON;
            end
         end
         ACENDE: begin
            if (fim_tempo) begin
               prox    = APAGA;
               carrega = 1'b1;
               valor   = RECARGA_OFF;
            end
         end
         APAGA: begin
            if (fim_tempo) prox = (endereco == ult_r) ? FIM : CARREGA;
         end
         FIM:     prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= OCIOSO;
         endereco <= '0;
         ult_r    <= '0;
         codigo_r <= APAGADO;
      end else begin
         estado <= prox;
         case (estado)
            OCIOSO: begin
               if (iniciar) begin
                  ult_r    <= ultimo;
                  endereco <= '0;
               end
            end
            LE: begin
               codigo_r <= dado_mem;
               if (prox == OCIOSO) endereco <= '0;
            end
            // Increment only when more elements remain, so the last index never wraps.
            APAGA: begin
               if (fim_tempo && (endereco != ult_r)) endereco <= endereco + 1'b1;
            end
            FIM:     endereco <= '0;
            default: ;
         endcase
      end
   end

   assign codigo_led = (estado == ACENDE) ? codigo_r : APAGADO;
   assign ocupado    = (estado == CARREGA) || (estado == LE) ||
                       (estado == ACENDE)  || (estado == APAGA);
   assign pronto     = (estado == FIM);
`ifdef VERIFICA_CODIGO_EN
   assign erro       = (estado == LE) && !eh_um_quente(dado_mem);
`endif

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia with T_ON=4, T_OFF=2.
module tb_exibe_sequencia;
   import genius_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [3:0] ultimo;
   logic [3:0] endereco;
   logic [3:0] dado_mem;
   logic [3:0] codigo_led;
   logic       ocupado;
   logic       pronto;
`ifdef VERIFICA_CODIGO_EN
   logic       erro;
`endif

   logic [3:0] mem [16];

   typedef struct packed {
      logic [3:0] led;
      logic       ocup;
      logic       pr;
      logic [3:0] ender;
   } item_t;

   item_t fila[$];
   int    n_cmp = 0;
   int    n_err = 0;
   bit    mon_on = 1'b0;

   always #5 clock = ~clock;

   exibe_sequencia #(.T_ON(4), .T_OFF(2), .ADDR_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .ultimo     (ultimo),
      .endereco   (endereco),
      .dado_mem   (dado_mem),
      .codigo_led (codigo_led),
      .ocupado    (ocupado),
`ifdef VERIFICA_CODIGO_EN
      .erro       (erro),
`endif
      .pronto     (pronto)
   );

   always @(posedge clock) dado_mem <= mem[endereco];

   // Monitor: every cycle with activity must match the next expected item.
   always @(negedge clock) begin
      item_t esp, obs;
      if (mon_on) begin
         obs = '{codigo_led, ocupado, pronto, endereco};
         if (ocupado || pronto) begin
            n_cmp++;
            if (fila.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got led=%b ocup=%b pronto=%b end=%0d required no activity",
                        codigo_led, ocupado, pronto, endereco);
            end else begin
               esp = fila.pop_front();
               if (obs !== esp) begin
                  n_err++;
                  $display("FAIL trace: got led=%b ocup=%b pronto=%b end=%0d required led=%b ocup=%b pronto=%b end=%0d",
                           obs.led, obs.ocup, obs.pr, obs.ender, esp.led, esp.ocup, esp.pr, esp.ender);
               end
            end
         end else if (codigo_led !== APAGADO) begin
            n_cmp++;
            n_err++;
            $display("FAIL led_idle: got %b required 0000", codigo_led);
         end
      end
   end

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nome, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_elem(input logic [3:0] c, input logic [3:0] a);
      fila.push_back('{APAGADO, 1'b1, 1'b0, a});
      fila.push_back('{APAGADO, 1'b1, 1'b0, a});
      repeat (4) fila.push_back('{c, 1'b1, 1'b0, a});
      repeat (2) fila.push_back('{APAGADO, 1'b1, 1'b0, a});
   endtask

   task automatic check_quiet(input string nome);
      chk(nome, {codigo_led, ocupado, pronto, endereco}, 32'h0);
   endtask

   // Plays mem[0..ult]; exp_n is the hand-computed cycle at which pronto shows
   // (cycle 0 = the cycle iniciar is high). perturba>0 re-raises iniciar mid-play.
   task automatic tocar(input logic [3:0] ult, input int exp_n, input int perturba);
      int n;
      bit visto;
      for (int i = 0; i <= int'(ult); i++) push_elem(mem[i], 4'(i));
      fila.push_back('{APAGADO, 1'b0, 1'b1, ult});
      iniciar = 1'b1;
      ultimo  = ult;
      n       = 0;
      visto   = 1'b0;
      while (!visto && n < exp_n + 20) begin
         tick();
         n++;
         if (n == 1) iniciar = 1'b0;
         if (perturba != 0 && n == perturba) begin
            iniciar = 1'b1;
            ultimo  = ~ult;
         end
         if (perturba != 0 && n == perturba + 2) begin
            iniciar = 1'b0;
            ultimo  = ult;
         end
         if (pronto === 1'b1) visto = 1'b1;
      end
      chk("pronto_latency", n, exp_n);
      tick();
      check_quiet("after_pronto");
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      iniciar = 1'b0;
      ultimo  = 4'd0;
      for (int i = 0; i < 16; i++) mem[i] = APAGADO;
      repeat (3) tick();
      reset  = 1'b0;
      mon_on = 1'b1;
      check_quiet("reset_state");

      // 1: idle with iniciar low
      for (int i = 0; i < 20; i++) begin
         tick();
         check_quiet("idle");
      end

      // 2: three-element sequence
      mem[0] = VERDE; mem[1] = AZUL; mem[2] = VERMELHO;
      tocar(4'd2, 25, 0);
      repeat (3) tick();

      // 3: single element, iniciar and ultimo disturbed mid-play
      mem[0] = AMARELO;
      tocar(4'd0, 9, 4);
      repeat (3) tick();

      // 4: full-depth sequence, no address wrap
      for (int i = 0; i < 16; i++) mem[i] = AZUL;
      tocar(4'd15, 129, 0);
      repeat (3) tick();

      // 5: reset during the second ACENDE, then restart from address 0
      mem[0] = VERDE; mem[1] = AZUL; mem[2] = VERMELHO;
      for (int i = 0; i < 3; i++) push_elem(mem[i], 4'(i));
      iniciar = 1'b1;
      ultimo  = 4'd2;
      n = 0;
      while (n < 12) begin
         tick();
         n++;
         if (n == 1) iniciar = 1'b0;
      end
      chk("led_before_reset", codigo_led, AZUL);
      reset = 1'b1;
      tick();
      fila.delete();
      check_quiet("after_midplay_reset");
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_quiet("no_pronto_after_reset");
      end
      tocar(4'd2, 25, 0);
      repeat (3) tick();

`ifdef VERIFICA_CODIGO_EN
      // 6: invalid code aborts playback with an erro pulse in LE of element 1
      mem[0] = VERDE; mem[1] = 4'b0110; mem[2] = VERMELHO;
      push_elem(VERDE, 4'd0);
      fila.push_back('{APAGADO, 1'b1, 1'b0, 4'd1});
      fila.push_back('{APAGADO, 1'b1, 1'b0, 4'd1});
      iniciar = 1'b1;
      ultimo  = 4'd2;
      n = 0;
      while (n < 16) begin
         tick();
         n++;
         if (n == 1) iniciar = 1'b0;
         chk("erro_pulse", erro, (n == 10) ? 1 : 0);
      end
      check_quiet("after_erro");
`endif

      chk("queue_empty", fila.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
